// File: rtl/core_rvfi_sequencer_if.sv
// Commit / memory-response / RVFI trace bundle for core_rvfi_sequencer.
// master: the core side (drives commit records and load responses).
// slave:  the sequencer (produces the RVFI trace and c_ready).
interface core_rvfi_sequencer_if #(
    parameter int XLEN = 64,
    parameter int ILEN = 32
);
    // commit port
    logic              c_valid;
    logic              c_ready;
    logic [ILEN-1:0]   c_insn;
    logic              c_trap;
    logic [XLEN-1:0]   c_pc_rdata;
    logic [XLEN-1:0]   c_pc_wdata;
    logic [4:0]        c_rd_addr;
    logic [XLEN-1:0]   c_rd_wdata;
    logic              c_load;
    logic [XLEN-1:0]   c_mem_addr;
    logic [XLEN/8-1:0] c_mem_rmask;
    logic [XLEN/8-1:0] c_mem_wmask;
    logic [XLEN-1:0]   c_mem_wdata;

    // load response port
    logic              m_rsp_valid;
    logic [XLEN-1:0]   m_rsp_rdata;
    logic [XLEN-1:0]   m_rsp_rd_wdata;

    // RVFI trace port
    logic              rvfi_valid;
    logic [63:0]       rvfi_order;
    logic [ILEN-1:0]   rvfi_insn;
    logic              rvfi_trap;
    logic              rvfi_halt;
    logic              rvfi_intr;
    logic [XLEN-1:0]   rvfi_pc_rdata;
    logic [XLEN-1:0]   rvfi_pc_wdata;
    logic [4:0]        rvfi_rd_addr;
    logic [XLEN-1:0]   rvfi_rd_wdata;
    logic [XLEN-1:0]   rvfi_mem_addr;
    logic [XLEN/8-1:0] rvfi_mem_rmask;
    logic [XLEN/8-1:0] rvfi_mem_wmask;
    logic [XLEN-1:0]   rvfi_mem_rdata;
    logic [XLEN-1:0]   rvfi_mem_wdata;

    logic              seq_err;

    modport master (
        output c_valid, c_insn, c_trap, c_pc_rdata, c_pc_wdata, c_rd_addr,
               c_rd_wdata, c_load, c_mem_addr, c_mem_rmask, c_mem_wmask,
               c_mem_wdata, m_rsp_valid, m_rsp_rdata, m_rsp_rd_wdata,
        input  c_ready, rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap,
               rvfi_halt, rvfi_intr, rvfi_pc_rdata, rvfi_pc_wdata,
               rvfi_rd_addr, rvfi_rd_wdata, rvfi_mem_addr, rvfi_mem_rmask,
               rvfi_mem_wmask, rvfi_mem_rdata, rvfi_mem_wdata, seq_err
    );

    modport slave (
        input  c_valid, c_insn, c_trap, c_pc_rdata, c_pc_wdata, c_rd_addr,
               c_rd_wdata, c_load, c_mem_addr, c_mem_rmask, c_mem_wmask,
               c_mem_wdata, m_rsp_valid, m_rsp_rdata, m_rsp_rd_wdata,
        output c_ready, rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap,
               rvfi_halt, rvfi_intr, rvfi_pc_rdata, rvfi_pc_wdata,
               rvfi_rd_addr, rvfi_rd_wdata, rvfi_mem_addr, rvfi_mem_rmask,
               rvfi_mem_wmask, rvfi_mem_rdata, rvfi_mem_wdata, seq_err
    );
endinterface

// File: rtl/core_rvfi_sequencer.sv
// In-order retirement sequencer between the commit point and the RVFI port.
// Records enter a DEPTH-entry circular buffer; loads stay pending until their
// response (returned in load order) fills in the read data. The head entry
// retires once it is no longer pending, one record per cycle.
// Optional: define CORE_RVFI_SEQ_INTR_EN to flag the record retired right
// after a trapped record on rvfi_intr; otherwise rvfi_intr is tied 0.
module core_rvfi_sequencer #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64,
    parameter int ILEN  = 32
) (
    input  logic                  g_clk,
    input  logic                  g_reset,
    core_rvfi_sequencer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [ILEN-1:0]   insn;
        logic              trap;
        logic [XLEN-1:0]   pc_rdata;
        logic [XLEN-1:0]   pc_wdata;
        logic [4:0]        rd_addr;
        logic [XLEN-1:0]   rd_wdata;
        logic [XLEN-1:0]   mem_addr;
        logic [XLEN/8-1:0] mem_rmask;
        logic [XLEN/8-1:0] mem_wmask;
        logic [XLEN-1:0]   mem_rdata;
        logic [XLEN-1:0]   mem_wdata;
    } entry_t;

    entry_t          ent_q [DEPTH];
    logic [AW-1:0]   idx_mem_q [DEPTH];
    logic [DEPTH-1:0] pending_q;
    logic [AW-1:0]   head_q, tail_q;
    logic [CW-1:0]   count_q;
    logic [AW-1:0]   idx_head_q, idx_tail_q;
    logic [CW-1:0]   idx_count_q;
    logic [63:0]     order_cnt_q;
    logic            seq_err_q;

    logic            rvfi_valid_q;
    logic [63:0]     rvfi_order_q;
    entry_t          rvfi_ent_q;

    logic            push, push_pending, idx_push, rsp, retire;
    logic [AW-1:0]   rsp_idx;
    entry_t          new_ent;

    assign bus.c_ready  = (count_q != CW'(DEPTH));
    assign push         = bus.c_valid && bus.c_ready;
    assign push_pending = bus.c_load && !bus.c_trap;
    assign idx_push     = push && push_pending;
    // Only loads already in the index FIFO can match a response; a load
    // pushed this same cycle is not visible here yet.
    assign rsp          = bus.m_rsp_valid && (idx_count_q != '0);
    assign rsp_idx      = idx_mem_q[idx_head_q];
    assign retire       = (count_q != '0) && !pending_q[head_q];

    // Build the buffer entry for an incoming commit record.
    always_comb begin
        new_ent           = '0;
        new_ent.insn      = bus.c_insn;
        new_ent.trap      = bus.c_trap;
        new_ent.pc_rdata  = bus.c_pc_rdata;
        new_ent.pc_wdata  = bus.c_pc_wdata;
        new_ent.rd_addr   = bus.c_rd_addr;
        new_ent.rd_wdata  = (bus.c_rd_addr == 5'd0 || push_pending) ? '0 : bus.c_rd_wdata;
        new_ent.mem_addr  = bus.c_mem_addr;
        new_ent.mem_rmask = bus.c_mem_rmask;
        new_ent.mem_wmask = bus.c_mem_wmask;
        new_ent.mem_rdata = '0;
        new_ent.mem_wdata = bus.c_mem_wdata;
    end

    // Entry and index storage: written on push and on load response.
    // NOTE: storage arrays carry no reset; the pointers and pending flags
    // guarantee an entry is always written before it is read.
    always_ff @(posedge g_clk) begin
        if (push) begin
            ent_q[tail_q] <= new_ent;
        end
        if (idx_push) begin
            idx_mem_q[idx_tail_q] <= tail_q;
        end
        if (rsp) begin
            ent_q[rsp_idx].mem_rdata <= bus.m_rsp_rdata;
            ent_q[rsp_idx].rd_wdata  <= (ent_q[rsp_idx].rd_addr == 5'd0) ? '0 : bus.m_rsp_rd_wdata;
        end
    end

    // Pointers, pending flags, error flag and the registered RVFI outputs.
    // NOTE: all state here uses non-blocking assignments so every read sees
    // the pre-edge value, which makes same-cycle push/response/retire safe.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            idx_head_q   <= '0;
            idx_tail_q   <= '0;
            idx_count_q  <= '0;
            pending_q    <= '0;
            order_cnt_q  <= '0;
            seq_err_q    <= 1'b0;
            rvfi_valid_q <= 1'b0;
            rvfi_order_q <= '0;
            rvfi_ent_q   <= '0;
        end else begin
            count_q     <= count_q + CW'(push) - CW'(retire);
            idx_count_q <= idx_count_q + CW'(idx_push) - CW'(rsp);
            if (push) begin
                tail_q            <= tail_q + AW'(1);
                pending_q[tail_q] <= push_pending;
            end
            if (idx_push) begin
                idx_tail_q <= idx_tail_q + AW'(1);
            end
            if (rsp) begin
                pending_q[rsp_idx] <= 1'b0;
                idx_head_q         <= idx_head_q + AW'(1);
            end
            if (bus.m_rsp_valid && idx_count_q == '0) begin
                seq_err_q <= 1'b1;
            end
            rvfi_valid_q <= retire;
            if (retire) begin
                rvfi_ent_q   <= ent_q[head_q];
                rvfi_order_q <= order_cnt_q;
                order_cnt_q  <= order_cnt_q + 64'd1;
                head_q       <= head_q + AW'(1);
            end
        end
    end

`ifdef CORE_RVFI_SEQ_INTR_EN
    logic trap_seen_q;
    logic rvfi_intr_q;

    // Remember a retired trap so the next retired record is marked as the
    // first instruction of the handler.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            trap_seen_q <= 1'b0;
            rvfi_intr_q <= 1'b0;
        end else if (retire) begin
            rvfi_intr_q <= trap_seen_q;
            trap_seen_q <= ent_q[head_q].trap;
        end
    end

    assign bus.rvfi_intr = rvfi_intr_q;
`else
    assign bus.rvfi_intr = 1'b0;
`endif

    assign bus.rvfi_valid     = rvfi_valid_q;
    assign bus.rvfi_order     = rvfi_order_q;
    assign bus.rvfi_insn      = rvfi_ent_q.insn;
    assign bus.rvfi_trap      = rvfi_ent_q.trap;
    assign bus.rvfi_halt      = 1'b0;
    assign bus.rvfi_pc_rdata  = rvfi_ent_q.pc_rdata;
    assign bus.rvfi_pc_wdata  = rvfi_ent_q.pc_wdata;
    assign bus.rvfi_rd_addr   = rvfi_ent_q.rd_addr;
    assign bus.rvfi_rd_wdata  = rvfi_ent_q.rd_wdata;
    assign bus.rvfi_mem_addr  = rvfi_ent_q.mem_addr;
    assign bus.rvfi_mem_rmask = rvfi_ent_q.mem_rmask;
    assign bus.rvfi_mem_wmask = rvfi_ent_q.mem_wmask;
    assign bus.rvfi_mem_rdata = rvfi_ent_q.mem_rdata;
    assign bus.rvfi_mem_wdata = rvfi_ent_q.mem_wdata;
    assign bus.seq_err        = seq_err_q;
endmodule

// File: tb/tb_core_rvfi_sequencer.sv
// Scoreboard bench for core_rvfi_sequencer: expected trace records are queued
// when commits are accepted, completed when load responses are driven, and
// compared against every rvfi_valid pulse. Directed checks cover timing.
module tb_core_rvfi_sequencer;
    localparam int XLEN  = 64;
    localparam int ILEN  = 32;
    localparam int DEPTH = 4;

    logic g_clk = 1'b0;
    logic g_reset;
    always #5 g_clk = ~g_clk;

    core_rvfi_sequencer_if #(.XLEN(XLEN), .ILEN(ILEN)) bus();

    core_rvfi_sequencer #(.DEPTH(DEPTH), .XLEN(XLEN), .ILEN(ILEN)) dut (
        .g_clk   (g_clk),
        .g_reset (g_reset),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] insn;
        logic        trap;
        logic [63:0] pc_rdata;
        logic [63:0] pc_wdata;
        logic [4:0]  rd_addr;
        logic [63:0] rd_wdata;
        logic [63:0] mem_addr;
        logic [7:0]  mem_rmask;
        logic [7:0]  mem_wmask;
        logic [63:0] mem_rdata;
        logic [63:0] mem_wdata;
        logic        intr;
    } rec_t;

    rec_t        exp_q[$];
    int unsigned load_q[$];
    int unsigned push_seq, pop_seq;
    logic [63:0] exp_order;
    logic        last_trap;
    int          n_checks, n_pass, n_ret;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    endtask

    task automatic clear_model();
        exp_q.delete();
        load_q.delete();
        push_seq  = 0;
        pop_seq   = 0;
        exp_order = '0;
        last_trap = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge g_clk);
            #1;
        end
    endtask

    // Present one commit record, hold it until accepted, then queue its
    // expected trace record.
    task automatic commit(input logic [63:0] pc, input logic load, input logic trap,
                          input logic [4:0] rd, input logic [63:0] wdata);
        rec_t r;
        logic rdy;
        r.insn      = {pc[29:0], 2'b11};
        r.trap      = trap;
        r.pc_rdata  = pc;
        r.pc_wdata  = pc + 64'd4;
        r.rd_addr   = rd;
        r.mem_addr  = load ? (64'h8000 + pc) : 64'h0;
        r.mem_rmask = load ? 8'hff : 8'h00;
        r.mem_wmask = load ? 8'h00 : 8'h0f;
        r.mem_wdata = wdata ^ 64'h1;
        r.mem_rdata = '0;
        bus.c_valid     = 1'b1;
        bus.c_insn      = r.insn;
        bus.c_trap      = trap;
        bus.c_pc_rdata  = pc;
        bus.c_pc_wdata  = r.pc_wdata;
        bus.c_rd_addr   = rd;
        bus.c_rd_wdata  = wdata;
        bus.c_load      = load;
        bus.c_mem_addr  = r.mem_addr;
        bus.c_mem_rmask = r.mem_rmask;
        bus.c_mem_wmask = r.mem_wmask;
        bus.c_mem_wdata = r.mem_wdata;
        rdy = 1'b0;
        for (int i = 0; i < 50 && !rdy; i++) begin
            @(negedge g_clk);
            rdy = bus.c_ready;
            @(posedge g_clk);
            #1;
        end
        bus.c_valid = 1'b0;
        if (!rdy) begin
            check("commit_timeout", 64'd0, 64'd1);
        end else begin
            r.rd_wdata = (rd == 5'd0 || (load && !trap)) ? 64'h0 : wdata;
`ifdef CORE_RVFI_SEQ_INTR_EN
            r.intr = last_trap;
`else
            r.intr = 1'b0;
`endif
            last_trap = trap;
            exp_q.push_back(r);
            if (load && !trap) load_q.push_back(push_seq);
            push_seq++;
        end
    endtask

    // Drive one load response for a single cycle and complete the oldest
    // outstanding expected load record.
    task automatic respond(input logic [63:0] rdata, input logic [63:0] rdw);
        int unsigned s;
        int          i;
        bus.m_rsp_valid    = 1'b1;
        bus.m_rsp_rdata    = rdata;
        bus.m_rsp_rd_wdata = rdw;
        @(posedge g_clk);
        if (load_q.size() != 0) begin
            s = load_q.pop_front();
            i = int'(s - pop_seq);
            exp_q[i].mem_rdata = rdata;
            exp_q[i].rd_wdata  = (exp_q[i].rd_addr == 5'd0) ? 64'h0 : rdw;
        end
        #1;
        bus.m_rsp_valid = 1'b0;
    endtask

    // Trace monitor: every retire pulse is compared with the oldest record.
    always @(negedge g_clk) begin
        rec_t r;
        if (!g_reset && bus.rvfi_valid) begin
            n_ret++;
            if (exp_q.size() == 0) begin
                check("spurious_retire", 64'd1, 64'd0);
            end else begin
                r = exp_q.pop_front();
                pop_seq++;
                check("order",     bus.rvfi_order,     exp_order);
                exp_order++;
                check("insn",      64'(bus.rvfi_insn), 64'(r.insn));
                check("trap",      64'(bus.rvfi_trap), 64'(r.trap));
                check("pc_rdata",  bus.rvfi_pc_rdata,  r.pc_rdata);
                check("pc_wdata",  bus.rvfi_pc_wdata,  r.pc_wdata);
                check("rd_addr",   64'(bus.rvfi_rd_addr), 64'(r.rd_addr));
                check("rd_wdata",  bus.rvfi_rd_wdata,  r.rd_wdata);
                check("mem_addr",  bus.rvfi_mem_addr,  r.mem_addr);
                check("mem_rmask", 64'(bus.rvfi_mem_rmask), 64'(r.mem_rmask));
                check("mem_wmask", 64'(bus.rvfi_mem_wmask), 64'(r.mem_wmask));
                check("mem_rdata", bus.rvfi_mem_rdata, r.mem_rdata);
                check("mem_wdata", bus.rvfi_mem_wdata, r.mem_wdata);
                check("intr",      64'(bus.rvfi_intr), 64'(r.intr));
                check("halt",      64'(bus.rvfi_halt), 64'd0);
            end
        end
    end

    initial begin
        int nr;
        n_checks = 0;
        n_pass   = 0;
        n_ret    = 0;
        g_reset  = 1'b1;
        bus.c_valid = 1'b0;  bus.c_insn = '0;      bus.c_trap = 1'b0;
        bus.c_pc_rdata = '0; bus.c_pc_wdata = '0;  bus.c_rd_addr = '0;
        bus.c_rd_wdata = '0; bus.c_load = 1'b0;    bus.c_mem_addr = '0;
        bus.c_mem_rmask = '0; bus.c_mem_wmask = '0; bus.c_mem_wdata = '0;
        bus.m_rsp_valid = 1'b0; bus.m_rsp_rdata = '0; bus.m_rsp_rd_wdata = '0;
        clear_model();
        tick(2);
        g_reset = 1'b0;

        // reset state
        check("rst_valid",   64'(bus.rvfi_valid), 64'd0);
        check("rst_order",   bus.rvfi_order,      64'd0);
        check("rst_ready",   64'(bus.c_ready),    64'd1);
        check("rst_seq_err", 64'(bus.seq_err),    64'd0);
        check("rst_pc",      bus.rvfi_pc_rdata,   64'd0);
        check("rst_rd_wdata", bus.rvfi_rd_wdata,  64'd0);
        check("rst_intr",    64'(bus.rvfi_intr),  64'd0);

        // three back-to-back non-loads: pulses on consecutive cycles
        commit(64'h10, 1'b0, 1'b0, 5'd1, 64'h11);
        check("t1_no_pulse_at_accept", 64'(bus.rvfi_valid), 64'd0);
        commit(64'h14, 1'b0, 1'b0, 5'd2, 64'h22);
        check("t1_pulse0", 64'(bus.rvfi_valid), 64'd1);
        check("t1_order0", bus.rvfi_order, 64'd0);
        commit(64'h18, 1'b0, 1'b0, 5'd3, 64'h33);
        check("t1_pulse1", 64'(bus.rvfi_valid), 64'd1);
        check("t1_order1", bus.rvfi_order, 64'd1);
        tick(1);
        check("t1_pulse2", 64'(bus.rvfi_valid), 64'd1);
        check("t1_order2", bus.rvfi_order, 64'd2);
        tick(1);
        check("t1_idle", 64'(bus.rvfi_valid), 64'd0);

        // load then ALU op: ALU must wait behind the pending load
        commit(64'h100, 1'b1, 1'b0, 5'd5, 64'h0);
        commit(64'h104, 1'b0, 1'b0, 5'd6, 64'h66);
        nr = n_ret;
        tick(5);
        check("t2_held_while_pending", 64'(n_ret), 64'(nr));
        respond(64'hDEAD, 64'hDEAD);
        check("t2_no_pulse_at_rsp", 64'(bus.rvfi_valid), 64'd0);
        tick(1);
        check("t2_load_first_valid", 64'(bus.rvfi_valid), 64'd1);
        check("t2_load_first_pc",    bus.rvfi_pc_rdata,   64'h100);
        check("t2_load_rdata",       bus.rvfi_mem_rdata,  64'hDEAD);
        tick(1);
        check("t2_alu_second_pc",    bus.rvfi_pc_rdata,   64'h104);
        tick(1);

        // fill with pending loads across pointer wrap
        for (int i = 0; i < DEPTH; i++)
            commit(64'h200 + 64'(4 * i), 1'b1, 1'b0, 5'(7 + i), 64'h0);
        check("t3_full_not_ready", 64'(bus.c_ready), 64'd0);
        respond(64'h1111_0000, 64'h1111);
        check("t3_still_full", 64'(bus.c_ready), 64'd0);
        tick(1);
        check("t3_ready_back", 64'(bus.c_ready), 64'd1);
        check("t3_retired", 64'(bus.rvfi_valid), 64'd1);
        for (int i = 0; i < DEPTH - 1; i++)
            respond(64'h2222_0000 + 64'(i), 64'h3333 + 64'(i));
        tick(3);

        // response with nothing pending
        respond(64'hBAD, 64'hBAD);
        check("t4_seq_err", 64'(bus.seq_err), 64'd1);
        nr = n_ret;
        tick(2);
        check("t4_no_retire", 64'(n_ret), 64'(nr));

        // rd = x0 masking, trapped load, load to x0
        commit(64'h300, 1'b0, 1'b0, 5'd0, 64'h55);
        tick(1);
        check("t5_x0_valid",    64'(bus.rvfi_valid), 64'd1);
        check("t5_x0_rd_wdata", bus.rvfi_rd_wdata,   64'd0);
        check("t4_seq_err_sticky", 64'(bus.seq_err), 64'd1);
        commit(64'h304, 1'b1, 1'b1, 5'd12, 64'h77);
        tick(1);
        check("t5_trap_load_valid", 64'(bus.rvfi_valid), 64'd1);
        check("t5_trap_load_trap",  64'(bus.rvfi_trap),  64'd1);
`ifdef CORE_RVFI_SEQ_INTR_EN
        check("t6_trap_intr0", 64'(bus.rvfi_intr), 64'd0);
`endif
        commit(64'h308, 1'b0, 1'b0, 5'd13, 64'h88);
        tick(1);
        check("t6_handler_valid", 64'(bus.rvfi_valid), 64'd1);
`ifdef CORE_RVFI_SEQ_INTR_EN
        check("t6_handler_intr1", 64'(bus.rvfi_intr), 64'd1);
`endif
        commit(64'h30c, 1'b1, 1'b0, 5'd0, 64'h0);
        respond(64'hABCD, 64'h1234);
        tick(2);

        // reset with entries queued and a response held during reset
        commit(64'h310, 1'b1, 1'b0, 5'd14, 64'h0);
        commit(64'h314, 1'b0, 1'b0, 5'd15, 64'h99);
        g_reset = 1'b1;
        bus.m_rsp_valid = 1'b1;
        bus.m_rsp_rdata = 64'h77;
        bus.m_rsp_rd_wdata = 64'h77;
        tick(2);
        g_reset = 1'b0;
        bus.m_rsp_valid = 1'b0;
        clear_model();
        check("t7_seq_err_cleared", 64'(bus.seq_err),    64'd0);
        check("t7_ready",           64'(bus.c_ready),    64'd1);
        check("t7_valid",           64'(bus.rvfi_valid), 64'd0);
        nr = n_ret;
        tick(4);
        check("t7_no_retire", 64'(n_ret), 64'(nr));
        commit(64'h400, 1'b0, 1'b0, 5'd1, 64'h44);
        tick(1);
        check("t7_restart_valid", 64'(bus.rvfi_valid), 64'd1);
        check("t7_restart_order", bus.rvfi_order,      64'd0);

        // drain
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick(1);
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        check("final_seq_err", 64'(bus.seq_err), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
